// File: rtl/n_term_ram_io_pkg.sv
// Shared definitions for the north-edge RAM I/O termination tile:
// FSM state encoding and bit positions within the N1/S1 wire groups.
package n_term_ram_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // S1BEG status bits
    localparam int unsigned RSP_VALID = 0;
    localparam int unsigned READY     = 1;
    localparam int unsigned RSP_WR    = 2;
    localparam int unsigned RSP_ERR   = 3;

    // N1END request bits
    localparam int unsigned REQ = 0;
    localparam int unsigned WR  = 1;

endpackage

// File: rtl/n_term_ram_io_bridge.sv
// North termination tile: decodes single-word RAM requests from the N wire ends,
// drives a synchronous RAM port and reports status/read data on the S wire beginnings.
module n_term_ram_io_bridge
    import n_term_ram_io_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              UserCLK,
    input  logic              resetn,
    input  logic [3:0]        N1END,
    input  logic [7:0]        N2MID,
    input  logic [7:0]        N2END,
    input  logic [15:0]       N4END,
    output logic [3:0]        S1BEG,
    output logic [7:0]        S2BEG,
    output logic [7:0]        S2BEGb,
    output logic [15:0]       S4BEG,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e              state_q, state_d;
    logic                req_prev_q;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [3:0]          s1_q, s1_d;
    logic [15:0]         s4_q, s4_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                req_edge_s;
    logic                range_err_s;
    logic                unused_s;

    assign unused_s    = ^N1END[3:2];
    assign req_edge_s  = N1END[REQ] & ~req_prev_q;
    // Address bits above ADDR_W must be zero; the shift yields 0 when ADDR_W is 8.
    assign range_err_s = (N2MID >> ADDR_W) != 8'd0;

    // Next-state logic for the request FSM, latency counter and RAM port.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        s4_d        = s4_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_edge_s) begin
                    wr_d = N1END[WR];
                    if (range_err_s) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = ST_ACCESS;
                        ram_en_d    = 1'b1;
                        ram_we_d    = N1END[WR];
                        ram_addr_d  = N2MID[ADDR_W-1:0];
                        ram_wdata_d = N4END;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'(RD_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    s4_d    = ram_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status bits are decoded from the next state so S1BEG is a clean register.
    always_comb begin
        s1_d            = 4'b0000;
        s1_d[RSP_VALID] = (state_d == ST_RESP);
        s1_d[READY]     = (state_d == ST_IDLE);
        s1_d[RSP_WR]    = (state_d == ST_RESP) & wr_d;
        s1_d[RSP_ERR]   = (state_d == ST_RESP) & err_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            req_prev_q  <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 2'd0;
            s1_q        <= 4'b0010;
            s4_q        <= 16'h0000;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= N1END[REQ];
            wr_q        <= wr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s4_q        <= s4_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Stateless bit-reversed loopback of the unused double wires.
    always_comb begin
        S2BEG  = 8'h00;
        S2BEGb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            S2BEG[i]  = N2MID[7-i];
            S2BEGb[i] = N2END[7-i];
        end
    end

    assign S1BEG     = s1_q;
    assign S4BEG     = s4_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_n_term_ram_io_bridge.sv
// Self-checking bench for n_term_ram_io_bridge (ADDR_W=6, RD_LATENCY=3) with a
// latency-accurate RAM model, vector table, corner sequences and randomized traffic.
module tb_n_term_ram_io_bridge;

    localparam int AW  = 6;
    localparam int LAT = 3;

    logic          UserCLK = 1'b0;
    logic          resetn  = 1'b0;
    logic [3:0]    N1END   = 4'h0;
    logic [7:0]    N2MID   = 8'h00;
    logic [7:0]    N2END   = 8'h00;
    logic [15:0]   N4END   = 16'h0000;
    logic [3:0]    S1BEG;
    logic [7:0]    S2BEG, S2BEGb;
    logic [15:0]   S4BEG;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int rsp_cnt = 0;

    logic [15:0] ref_mem [64];
    logic [15:0] s4_ref;

    n_term_ram_io_bridge #(.ADDR_W(AW), .DATA_W(16), .RD_LATENCY(LAT)) dut (
        .UserCLK(UserCLK), .resetn(resetn), .N1END(N1END), .N2MID(N2MID),
        .N2END(N2END), .N4END(N4END), .S1BEG(S1BEG), .S2BEG(S2BEG),
        .S2BEGb(S2BEGb), .S4BEG(S4BEG), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 UserCLK = ~UserCLK;

    // RAM with LAT-cycle read pipeline; non-read slots return a poison word.
    logic [15:0] ram_mem [64];
    logic [15:0] rd_pipe [LAT];
    always @(posedge UserCLK) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[LAT-1];

    // Pulse counters sampled away from the active edge.
    always @(negedge UserCLK) begin
        if (ram_en) en_cnt <= en_cnt + 1;
        if (S1BEG[0]) rsp_cnt <= rsp_cnt + 1;
    end

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        r = {<<{x}};
        return r;
    endfunction

    function automatic logic [15:0] init_word(input int a);
        return (a == 18) ? 16'hCAFE : {8'hA0 ^ 8'(a), 8'(a * 3)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request: drive the edge, watch the RAM port, time the response.
    task automatic do_txn(input logic wr, input logic [7:0] a, input logic [15:0] d,
                          input int exp_lat, input logic [3:0] exp_s1,
                          input logic [15:0] exp_s4, input string nm);
        int got;
        got = 0;
        @(negedge UserCLK);
        N1END = {2'b00, wr, 1'b1};
        N2MID = a;
        N4END = d;
        for (int c = 1; c <= 12; c++) begin
            @(negedge UserCLK);
            if (c == 1) begin
                N1END = 4'h0;
                chk({nm, ".ram_en"}, 32'(ram_en), 32'(exp_lat != 1));
                if (exp_lat != 1) begin
                    chk({nm, ".ram_we"}, 32'(ram_we), 32'(wr));
                    chk({nm, ".ram_addr"}, 32'(ram_addr), 32'(a[AW-1:0]));
                    if (wr) chk({nm, ".ram_wdata"}, 32'(ram_wdata), 32'(d));
                end
            end
            if (S1BEG[0]) begin
                got = c;
                break;
            end
        end
        chk({nm, ".latency"}, 32'(got), 32'(exp_lat));
        chk({nm, ".s1"}, 32'(S1BEG), 32'(exp_s1));
        chk({nm, ".s4"}, 32'(S4BEG), 32'(exp_s4));
        @(negedge UserCLK);
        chk({nm, ".s1_after"}, 32'(S1BEG), 32'h2);
    endtask

    // Reference model: outcome of a request from the documented rules.
    task automatic model_txn(input logic wr, input logic [7:0] a, input logic [15:0] d,
                             output int lat, output logic [3:0] s1);
        logic err;
        err = (a >= 8'd64);
        lat = err ? 1 : (wr ? 2 : 2 + LAT);
        s1  = {err, wr, 1'b0, 1'b1};
        if (!err && wr)  ref_mem[a % 64] = d;
        if (!err && !wr) s4_ref = ref_mem[a % 64];
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        int          lat;
        logic [3:0]  s1;
        logic [15:0] s4;
    } vec_t;

    vec_t vt [5];

    initial begin
        int e0, r0, lat;
        logic [3:0] s1;
        logic wr;
        logic [7:0] a;
        logic [15:0] d;

        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        s4_ref = 16'h0000;

        vt[0] = '{1'b0, 8'h12, 16'h0000, 2 + LAT, 4'b0001, 16'hCAFE};
        vt[1] = '{1'b1, 8'h12, 16'hBEEF, 2,       4'b0101, 16'hCAFE};
        vt[2] = '{1'b0, 8'h12, 16'h1234, 2 + LAT, 4'b0001, 16'hBEEF};
        vt[3] = '{1'b1, 8'h40, 16'h5555, 1,       4'b1101, 16'hBEEF};
        vt[4] = '{1'b0, 8'hC3, 16'h0000, 1,       4'b1001, 16'hBEEF};

        // Reset and idle state
        resetn = 1'b0;
        repeat (2) @(negedge UserCLK);
        chk("rst.s1", 32'(S1BEG), 32'h2);
        chk("rst.s4", 32'(S4BEG), 32'h0);
        chk("rst.ram_en", 32'(ram_en), 32'h0);
        chk("rst.ram_we", 32'(ram_we), 32'h0);
        chk("rst.ram_addr", 32'(ram_addr), 32'h0);
        chk("rst.ram_wdata", 32'(ram_wdata), 32'h0);
        resetn = 1'b1;
        N2END = 8'hA5;
        N2MID = 8'h12;
        @(negedge UserCLK);
        chk("loop.S2BEGb", 32'(S2BEGb), 32'hA5);
        chk("loop.S2BEG", 32'(S2BEG), 32'h48);
        chk("idle.s1", 32'(S1BEG), 32'h2);

        // Table of directed transactions
        for (int i = 0; i < 5; i++) begin
            do_txn(vt[i].wr, vt[i].a, vt[i].d, vt[i].lat, vt[i].s1, vt[i].s4,
                   $sformatf("vec%0d", i));
            model_txn(vt[i].wr, vt[i].a, vt[i].d, lat, s1);
        end

        // Level held for 20 cycles: exactly one access and one response
        e0 = en_cnt; r0 = rsp_cnt;
        @(negedge UserCLK);
        N1END = 4'b0001; N2MID = 8'h05;
        repeat (20) @(negedge UserCLK);
        N1END = 4'h0;
        repeat (3) @(negedge UserCLK);
        s4_ref = ref_mem[5];
        chk("hold.en_pulses", 32'(en_cnt - e0), 32'd1);
        chk("hold.rsp_pulses", 32'(rsp_cnt - r0), 32'd1);
        chk("hold.s4", 32'(S4BEG), 32'(s4_ref));

        // Second edge during WAIT is dropped
        e0 = en_cnt; r0 = rsp_cnt;
        N1END = 4'b0001; N2MID = 8'h07;
        @(negedge UserCLK); N1END = 4'b0000;
        @(negedge UserCLK); N1END = 4'b0001; N2MID = 8'h09;
        @(negedge UserCLK); N1END = 4'b0000;
        repeat (10) @(negedge UserCLK);
        s4_ref = ref_mem[7];
        chk("busy.en_pulses", 32'(en_cnt - e0), 32'd1);
        chk("busy.rsp_pulses", 32'(rsp_cnt - r0), 32'd1);
        chk("busy.s4", 32'(S4BEG), 32'(s4_ref));

        // Reset while waiting for read data
        r0 = rsp_cnt;
        N1END = 4'b0001; N2MID = 8'h09;
        @(negedge UserCLK); N1END = 4'b0000;
        @(negedge UserCLK); resetn = 1'b0;
        @(negedge UserCLK); resetn = 1'b1;
        s4_ref = 16'h0000;
        chk("wrst.s1", 32'(S1BEG), 32'h2);
        chk("wrst.s4", 32'(S4BEG), 32'h0);
        chk("wrst.ram_en", 32'(ram_en), 32'h0);
        repeat (6) @(negedge UserCLK);
        chk("wrst.no_rsp", 32'(rsp_cnt - r0), 32'd0);
        chk("wrst.s4_hold", 32'(S4BEG), 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                             : 8'($urandom_range(0, 63));
            d  = 16'($urandom);
            model_txn(wr, a, d, lat, s1);
            do_txn(wr, a, d, lat, s1, s4_ref, $sformatf("rnd%0d", n));
            N2END = 8'($urandom);
            #1;
            chk("rnd.S2BEGb", 32'(S2BEGb), 32'(rev8(N2END)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
